cmp4_arb: RTL and testbench
===========================

# cmp4_arb

Two-requester round-robin arbiter and sequencer for a single shared `cmp4` 4-bit magnitude comparator. Each requester presents an operand pair with a level request. The block grants one requester, latches its operands, and drives them into one internal `cmp4` instance. It then returns the registered lt/eq/gt result with a per-requester done pulse. Per-requester completed-operation counters support bandwidth checks.

## Interface
- `CNT_W`, 8: width of each saturating completed-operation counter.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req0`  in  1  requester 0 request (level).
- `a0`, `b0`  in  4 each  requester 0 operands.
- `req1`  in  1  requester 1 request (level).
- `a1`, `b1`  in  4 each  requester 1 operands.
- `gnt0`, `gnt1`  out  1 each  one-cycle grant pulse; operands are captured on the edge that raises it.
- `done0`, `done1`  out  1 each  one-cycle result-valid pulse to the served requester.
- `lt`, `eq`, `gt`  out  1 each  registered compare result, unsigned a vs b; shared by both requesters.
- `busy`  out  1  high while an operation is in flight (state CMP).
- `cnt0`, `cnt1`  out  CNT_W each  completed operations per requester; saturate at all-ones.

## Operation
- FSM with two states: IDLE, CMP. Reset state is IDLE.
- IDLE, no req: remain in IDLE; all pulses low.
- IDLE, exactly one req high: grant that requester.
- IDLE, both req high: grant the requester not served last. The `last` pointer resets to 1, so requester 0 wins the first tie.
- Grant edge:
  - capture the selected a/b into `op_a`/`op_b`;
  - store the owner id;
  - raise the matching gnt for one cycle;
  - update `last` to the owner;
  - go to CMP.
- CMP:
  - `cmp4` sees `op_a`/`op_b` combinationally.
  - On the next edge, register the `cmp4` lt/eq/gt outputs, pulse `done<owner>` for one cycle and increment `cnt<owner>` (no change at max).
  - Return to IDLE. Requests are ignored in CMP.
- After every done, exactly one of lt/eq/gt is 1.
- lt/eq/gt hold their value until the next done. They are not cleared when returning to IDLE.
- Requester protocol:
  - Hold req and operands stable until gnt is seen.
  - Operands are free to change from the cycle after gnt.
  - A req still high when the block is back in IDLE is treated as a new request.
- gnt and done are never high for both requesters in the same cycle. gnt and done never overlap for the same operation.

## Timing
- req sampled high at edge k (IDLE) → gnt high in cycle k..k+1.
- → done plus valid lt/eq/gt in cycle k+1..k+2.
- → earliest next grant at edge k+2.
- Throughput is one operation per 2 cycles. With both requesters continuously requesting, grants alternate 0,1,0,1.
- Reset values: `gnt0`=`gnt1`=`done0`=`done1`=0; `lt`=`eq`=`gt`=0 (no valid result before the first done); `busy`=0; `cnt0`=`cnt1`=0.
- Reset is asynchronous. Asserting `rst_n` in CMP aborts the operation: no done pulse, counters unchanged from their reset value of 0, state IDLE, `last`=1.
- After `rst_n` deasserts, the first edge may grant.
- A req change in the same cycle as done has no effect until the block is back in IDLE.

## Test plan
- Reset then idle: all outputs 0 for 5 cycles with `req0`=`req1`=0 → `busy`=0, no gnt.
- Single requester: `req0`=1, `a0`=3, `b0`=7 → `gnt0` next cycle, then `done0` with `lt`=1, `eq`=`gt`=0, `cnt0`=1. Repeat with 8/2 → `gt`=1 and 15/15 → `eq`=1.
- Tie and round-robin: both req held high for 8 cycles with `a1`=10, `b1`=9 and `a0`=9, `b0`=10 → grant order 0,1,0,1; results alternate `lt`/`gt`; `cnt0`=`cnt1`=2.
- Operand stability: change `a0` from 4 to 12 in the cycle after `gnt0`, with `b0`=4 → the result is `eq`=1, computed from the latched operand.
- Reset mid-op: assert `rst_n`=0 while `busy`=1 → no done, outputs at reset values immediately. After release with both req high → `gnt0` first.
- Counter saturation: with `CNT_W`=2, perform 5 requester-1 operations → `cnt1`=3.

Source files
------------

// File: rtl/cmp4_arb_if.sv
// Requester-side bundle for cmp4_arb: two request/operand ports, grant/done
// pulses, the shared compare result and the per-requester completion counters.
interface cmp4_arb_if #(
   parameter int CNT_W = 8
);
   logic             req0;
   logic [3:0]       a0;
   logic [3:0]       b0;
   logic             req1;
   logic [3:0]       a1;
   logic [3:0]       b1;
   logic             gnt0;
   logic             gnt1;
   logic             done0;
   logic             done1;
   logic             lt;
   logic             eq;
   logic             gt;
   logic             busy;
   logic [CNT_W-1:0] cnt0;
   logic [CNT_W-1:0] cnt1;

   modport slave (
      input  req0, a0, b0, req1, a1, b1,
      output gnt0, gnt1, done0, done1, lt, eq, gt, busy, cnt0, cnt1
   );

   modport master (
      output req0, a0, b0, req1, a1, b1,
      input  gnt0, gnt1, done0, done1, lt, eq, gt, busy, cnt0, cnt1
   );
endinterface

// File: rtl/cmp4_arb.sv
// Round-robin arbiter sharing one 4-bit unsigned magnitude comparator between
// two requesters; one operation every two cycles, results registered on done.
module cmp4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic       lt,
   output logic       eq,
   output logic       gt
);
   assign lt = (a <  b);
   assign eq = (a == b);
   assign gt = (a >  b);
endmodule

module cmp4_arb #(
   parameter int CNT_W = 8
) (
   input  logic      clk,
   input  logic      rst_n,
   cmp4_arb_if.slave bus
);
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      CMP  = 1'b1
   } state_t;

   state_t           state_r;
   logic             last_r;
   logic             owner_r;
   logic [3:0]       op_a_r;
   logic [3:0]       op_b_r;
   logic             gnt0_r;
   logic             gnt1_r;
   logic             done0_r;
   logic             done1_r;
   logic             lt_r;
   logic             eq_r;
   logic             gt_r;
   logic             busy_r;
   logic [CNT_W-1:0] cnt0_r;
   logic [CNT_W-1:0] cnt1_r;

   logic             sel_valid_s;
   logic             sel_id_s;
   logic             lt_s;
   logic             eq_s;
   logic             gt_s;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (&v) begin
         return v;
      end else begin
         return v + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   endfunction

   cmp4 u_cmp4 (
      .a  (op_a_r),
      .b  (op_b_r),
      .lt (lt_s),
      .eq (eq_s),
      .gt (gt_s)
   );

   // Pick the requester to grant; on a tie the one not served last wins.
   always_comb begin
      sel_valid_s = 1'b0;
      sel_id_s    = 1'b0;
      if (bus.req0 && bus.req1) begin
         sel_valid_s = 1'b1;
         sel_id_s    = ~last_r;
      end else if (bus.req0) begin
         sel_valid_s = 1'b1;
         sel_id_s    = 1'b0;
      end else if (bus.req1) begin
         sel_valid_s = 1'b1;
         sel_id_s    = 1'b1;
      end else begin
         sel_valid_s = 1'b0;
         sel_id_s    = 1'b0;
      end
   end

   // Grant/compare sequencer with all outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         last_r  <= 1'b1;
         owner_r <= 1'b0;
         op_a_r  <= 4'd0;
         op_b_r  <= 4'd0;
         gnt0_r  <= 1'b0;
         gnt1_r  <= 1'b0;
         done0_r <= 1'b0;
         done1_r <= 1'b0;
         lt_r    <= 1'b0;
         eq_r    <= 1'b0;
         gt_r    <= 1'b0;
         busy_r  <= 1'b0;
         cnt0_r  <= {CNT_W{1'b0}};
         cnt1_r  <= {CNT_W{1'b0}};
      end else begin
         gnt0_r  <= 1'b0;
         gnt1_r  <= 1'b0;
         done0_r <= 1'b0;
         done1_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (sel_valid_s) begin
                  op_a_r  <= sel_id_s ? bus.a1 : bus.a0;
                  op_b_r  <= sel_id_s ? bus.b1 : bus.b0;
                  owner_r <= sel_id_s;
                  last_r  <= sel_id_s;
                  gnt0_r  <= ~sel_id_s;
                  gnt1_r  <= sel_id_s;
                  busy_r  <= 1'b1;
                  state_r <= CMP;
               end else begin
                  busy_r  <= 1'b0;
                  state_r <= IDLE;
               end
            end
            CMP: begin
               lt_r <= lt_s;
               eq_r <= eq_s;
               gt_r <= gt_s;
               if (owner_r == 1'b0) begin
                  done0_r <= 1'b1;
                  cnt0_r  <= sat_inc(cnt0_r);
               end else begin
                  done1_r <= 1'b1;
                  cnt1_r  <= sat_inc(cnt1_r);
               end
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign bus.gnt0  = gnt0_r;
   assign bus.gnt1  = gnt1_r;
   assign bus.done0 = done0_r;
   assign bus.done1 = done1_r;
   assign bus.lt    = lt_r;
   assign bus.eq    = eq_r;
   assign bus.gt    = gt_r;
   assign bus.busy  = busy_r;
   assign bus.cnt0  = cnt0_r;
   assign bus.cnt1  = cnt1_r;
endmodule

// File: tb/tb_cmp4_arb.sv
// Directed bench for cmp4_arb: default-width instance for function and
// round-robin behaviour, a 2-bit-counter instance for counter saturation.
module tb_cmp4_arb;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   cmp4_arb_if #(.CNT_W(8)) bus ();
   cmp4_arb_if #(.CNT_W(2)) bus2 ();

   cmp4_arb #(.CNT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   cmp4_arb #(.CNT_W(2)) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with the arbiter idle; leg is {lt,eq,gt}.
   task automatic op0(input logic [3:0] a, input logic [3:0] b,
                      input logic [2:0] leg, input logic [7:0] cnt);
      bus.req0 = 1'b1;
      bus.a0   = a;
      bus.b0   = b;
      @(negedge clk);
      chk("op0_gnt0", 32'(bus.gnt0), 32'd1);
      chk("op0_gnt1", 32'(bus.gnt1), 32'd0);
      chk("op0_busy", 32'(bus.busy), 32'd1);
      chk("op0_done_early", 32'(bus.done0), 32'd0);
      bus.req0 = 1'b0;
      @(negedge clk);
      chk("op0_done0", 32'(bus.done0), 32'd1);
      chk("op0_done1", 32'(bus.done1), 32'd0);
      chk("op0_result", 32'({bus.lt, bus.eq, bus.gt}), 32'(leg));
      chk("op0_cnt0", 32'(bus.cnt0), 32'(cnt));
      chk("op0_busy_end", 32'(bus.busy), 32'd0);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      bus.req0  = 1'b0; bus.a0  = 4'd0; bus.b0  = 4'd0;
      bus.req1  = 1'b0; bus.a1  = 4'd0; bus.b1  = 4'd0;
      bus2.req0 = 1'b0; bus2.a0 = 4'd0; bus2.b0 = 4'd0;
      bus2.req1 = 1'b0; bus2.a1 = 4'd0; bus2.b1 = 4'd0;

      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_outs", 32'({bus.gnt0, bus.gnt1, bus.done0, bus.done1,
                           bus.lt, bus.eq, bus.gt, bus.busy}), 32'd0);
      chk("rst_cnt0", 32'(bus.cnt0), 32'd0);
      chk("rst_cnt1", 32'(bus.cnt1), 32'd0);
      rst_n = 1'b1;

      // Idle with no requests
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("idle_busy", 32'(bus.busy), 32'd0);
         chk("idle_gnt", 32'({bus.gnt0, bus.gnt1}), 32'd0);
         chk("idle_done", 32'({bus.done0, bus.done1}), 32'd0);
      end

      // Single requester: lt, eq, gt, then latched-operand check
      op0(4'd3,  4'd7,  3'b100, 8'd1);
      op0(4'd15, 4'd15, 3'b010, 8'd2);
      op0(4'd8,  4'd2,  3'b001, 8'd3);

      bus.req0 = 1'b1; bus.a0 = 4'd4; bus.b0 = 4'd4;
      @(negedge clk);
      chk("stab_gnt0", 32'(bus.gnt0), 32'd1);
      bus.req0 = 1'b0; bus.a0 = 4'd12;
      @(negedge clk);
      chk("stab_done0", 32'(bus.done0), 32'd1);
      chk("stab_result", 32'({bus.lt, bus.eq, bus.gt}), 32'b010);
      chk("stab_cnt0", 32'(bus.cnt0), 32'd4);
      chk("stab_cnt1", 32'(bus.cnt1), 32'd0);

      // Reset while an operation is in flight
      bus.req0 = 1'b1; bus.a0 = 4'd1; bus.b0 = 4'd2;
      @(negedge clk);
      chk("mid_busy", 32'(bus.busy), 32'd1);
      rst_n = 1'b0; bus.req0 = 1'b0;
      #1;
      chk("mid_rst_outs", 32'({bus.gnt0, bus.gnt1, bus.done0, bus.done1,
                               bus.lt, bus.eq, bus.gt, bus.busy}), 32'd0);
      chk("mid_rst_cnt0", 32'(bus.cnt0), 32'd0);
      @(negedge clk);
      chk("mid_no_done", 32'({bus.done0, bus.done1}), 32'd0);

      // Release with both requesting: 0 wins first, then strict alternation
      rst_n = 1'b1;
      bus.req0 = 1'b1; bus.a0 = 4'd9;  bus.b0 = 4'd10;
      bus.req1 = 1'b1; bus.a1 = 4'd10; bus.b1 = 4'd9;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rr_gnt0", 32'(bus.gnt0), (i % 2 == 0) ? 32'd1 : 32'd0);
         chk("rr_gnt1", 32'(bus.gnt1), (i % 2 == 0) ? 32'd0 : 32'd1);
         @(negedge clk);
         chk("rr_done0", 32'(bus.done0), (i % 2 == 0) ? 32'd1 : 32'd0);
         chk("rr_done1", 32'(bus.done1), (i % 2 == 0) ? 32'd0 : 32'd1);
         chk("rr_result", 32'({bus.lt, bus.eq, bus.gt}),
             (i % 2 == 0) ? 32'b100 : 32'b001);
      end
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      chk("rr_cnt0", 32'(bus.cnt0), 32'd2);
      chk("rr_cnt1", 32'(bus.cnt1), 32'd2);
      @(negedge clk);
      chk("rr_quiet", 32'({bus.gnt0, bus.gnt1, bus.busy}), 32'd0);

      // Counter saturation on the 2-bit instance
      for (int k = 0; k < 5; k++) begin
         bus2.req1 = 1'b1; bus2.a1 = 4'd2; bus2.b1 = 4'd5;
         @(negedge clk);
         chk("sat_gnt1", 32'(bus2.gnt1), 32'd1);
         bus2.req1 = 1'b0;
         @(negedge clk);
         chk("sat_done1", 32'(bus2.done1), 32'd1);
         chk("sat_result", 32'({bus2.lt, bus2.eq, bus2.gt}), 32'b100);
         chk("sat_cnt1", 32'(bus2.cnt1), (k < 3) ? 32'(k + 1) : 32'd3);
      end
      chk("sat_cnt0", 32'(bus2.cnt0), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
